// File: rtl/wb_lane_arbiter_if.sv
// Bundle of execution-unit result requests and the two writeback lanes they are packed onto.
interface wb_lane_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int SID_W = 5
);
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*5-1:0]     req_rd_i;
    logic [NREQ*64-1:0]    req_value_i;
    logic [NREQ*32-1:0]    req_inst_i;
    logic [NREQ*SID_W-1:0] req_sid_i;
    logic [NREQ-1:0]       req_redirect_i;
    logic [NREQ*64-1:0]    req_redirect_pc_i;

    logic                  inst0_wb_valid_o;
    logic [4:0]            inst0_wb_rd_o;
    logic [63:0]           inst0_wb_value_o;
    logic [31:0]           inst0_wb_inst_o;
    logic [SID_W-1:0]      inst0_wb_sid_o;
    logic                  inst0_wb_redirect_o;
    logic [63:0]           inst0_wb_redirect_pc_o;

    logic                  inst1_wb_valid_o;
    logic [4:0]            inst1_wb_rd_o;
    logic [63:0]           inst1_wb_value_o;
    logic [31:0]           inst1_wb_inst_o;
    logic [SID_W-1:0]      inst1_wb_sid_o;
    logic                  inst1_wb_redirect_o;
    logic [63:0]           inst1_wb_redirect_pc_o;

    // Arbiter side: consumes requests, produces grants and lane outputs.
    modport slave (
        input  req_valid_i, req_rd_i, req_value_i, req_inst_i, req_sid_i,
               req_redirect_i, req_redirect_pc_i,
        output req_ready_o,
        output inst0_wb_valid_o, inst0_wb_rd_o, inst0_wb_value_o, inst0_wb_inst_o,
               inst0_wb_sid_o, inst0_wb_redirect_o, inst0_wb_redirect_pc_o,
        output inst1_wb_valid_o, inst1_wb_rd_o, inst1_wb_value_o, inst1_wb_inst_o,
               inst1_wb_sid_o, inst1_wb_redirect_o, inst1_wb_redirect_pc_o
    );

    // Requester / writeback side.
    modport master (
        output req_valid_i, req_rd_i, req_value_i, req_inst_i, req_sid_i,
               req_redirect_i, req_redirect_pc_i,
        input  req_ready_o,
        input  inst0_wb_valid_o, inst0_wb_rd_o, inst0_wb_value_o, inst0_wb_inst_o,
               inst0_wb_sid_o, inst0_wb_redirect_o, inst0_wb_redirect_pc_o,
        input  inst1_wb_valid_o, inst1_wb_rd_o, inst1_wb_value_o, inst1_wb_inst_o,
               inst1_wb_sid_o, inst1_wb_redirect_o, inst1_wb_redirect_pc_o
    );
endinterface

// File: rtl/wb_lane_arbiter.sv
// Round-robin arbiter packing up to two execution-unit results per cycle onto the
// writeback lanes. Lane 0 always carries the first grant; a redirecting first grant
// closes the packet so lane 1 stays empty. Lane outputs are registered.
module wb_lane_arbiter #(
    parameter int NREQ  = 4,
    parameter int SID_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    wb_lane_arbiter_if.slave   bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] a_idx;
    logic [PTR_W-1:0] b_idx;
    logic             a_vld;
    logic             b_vld;
    logic [NREQ-1:0]  ready;

    // Pick the first two valid requesters in scan order starting at rr_ptr.
    always_comb begin
        a_vld    = 1'b0;
        b_vld    = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + i) % NREQ);
            if (bus.req_valid_i[scan_idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = scan_idx;
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = scan_idx;
                end
            end
        end
        // A redirect ends the packet; anything after it would be on the wrong path.
        if (a_vld && bus.req_redirect_i[a_idx]) begin
            b_vld = 1'b0;
        end
        if (flush_i) begin
            a_vld = 1'b0;
            b_vld = 1'b0;
        end
    end

    // Grant vector and the pointer value that follows the last granted requester.
    always_comb begin
        ready = '0;
        if (a_vld) begin
            ready[a_idx] = 1'b1;
        end
        if (b_vld) begin
            ready[b_idx] = 1'b1;
        end
        last_idx = b_vld ? b_idx : a_idx;
        ptr_next = PTR_W'((int'(last_idx) + 1) % NREQ);
    end

    assign bus.req_ready_o = ready;

    // Register lane outputs and advance the round-robin pointer on any grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr                     <= '0;
            bus.inst0_wb_valid_o       <= 1'b0;
            bus.inst0_wb_rd_o          <= '0;
            bus.inst0_wb_value_o       <= '0;
            bus.inst0_wb_inst_o        <= '0;
            bus.inst0_wb_sid_o         <= '0;
            bus.inst0_wb_redirect_o    <= 1'b0;
            bus.inst0_wb_redirect_pc_o <= '0;
            bus.inst1_wb_valid_o       <= 1'b0;
            bus.inst1_wb_rd_o          <= '0;
            bus.inst1_wb_value_o       <= '0;
            bus.inst1_wb_inst_o        <= '0;
            bus.inst1_wb_sid_o         <= '0;
            bus.inst1_wb_redirect_o    <= 1'b0;
            bus.inst1_wb_redirect_pc_o <= '0;
        end else begin
            bus.inst0_wb_valid_o    <= a_vld;
            bus.inst0_wb_redirect_o <= a_vld & bus.req_redirect_i[a_idx];
            bus.inst1_wb_valid_o    <= b_vld;
            bus.inst1_wb_redirect_o <= b_vld & bus.req_redirect_i[b_idx];
            // Data fields only load on a grant so idle lanes do not toggle.
            if (a_vld) begin
                bus.inst0_wb_rd_o          <= bus.req_rd_i[a_idx*5 +: 5];
                bus.inst0_wb_value_o       <= bus.req_value_i[a_idx*64 +: 64];
                bus.inst0_wb_inst_o        <= bus.req_inst_i[a_idx*32 +: 32];
                bus.inst0_wb_sid_o         <= bus.req_sid_i[a_idx*SID_W +: SID_W];
                bus.inst0_wb_redirect_pc_o <= bus.req_redirect_pc_i[a_idx*64 +: 64];
                rr_ptr                     <= ptr_next;
            end
            if (b_vld) begin
                bus.inst1_wb_rd_o          <= bus.req_rd_i[b_idx*5 +: 5];
                bus.inst1_wb_value_o       <= bus.req_value_i[b_idx*64 +: 64];
                bus.inst1_wb_inst_o        <= bus.req_inst_i[b_idx*32 +: 32];
                bus.inst1_wb_sid_o         <= bus.req_sid_i[b_idx*SID_W +: SID_W];
                bus.inst1_wb_redirect_pc_o <= bus.req_redirect_pc_i[b_idx*64 +: 64];
            end
        end
    end

endmodule
